// File: rtl/fifo_serial_tx.sv
// FIFO pop-side consumer: drains one word at a time and sends it as a UART frame.
// Optional even parity bit between data and stop when TX_PARITY_EN is defined.
module fifo_serial_tx #(
  parameter int WORDLENGHT = 8,
  parameter int BIT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  synch_rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [WORDLENGHT-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = $clog2(BIT_CYCLES);
  localparam int BIT_W  = $clog2(WORDLENGHT + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORDLENGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [WORDLENGHT-1:0] shift_q, shift_d;
`ifdef TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic baud_wrap;
  assign baud_wrap = (baud_q == BAUD_LAST);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
`ifdef TX_PARITY_EN
    parity_d   = parity_q;
`endif
    tx_out     = 1'b1;
    fifo_pop   = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_LOAD;
      S_LOAD: begin
        // The FIFO may have been cleared while we settled; bail out without popping.
        if (!fifo_empty) begin
          shift_d  = fifo_data;
          fifo_pop = 1'b1;
`ifdef TX_PARITY_EN
          parity_d = ^fifo_data;
`endif
          baud_d   = '0;
          state_d  = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tx_out = 1'b0;
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_out = shift_q[0];
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          shift_d = {1'b0, shift_q[WORDLENGHT-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        tx_out = parity_q;
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Synchronous clear wins over everything and must not let a pop escape.
    if (synch_rst) begin
      state_d  = S_IDLE;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = '0;
`ifdef TX_PARITY_EN
      parity_d = 1'b0;
`endif
      fifo_pop = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with a behavioural registered-read FIFO model.
// Build with +define+TX_PARITY_EN to exercise the parity frame.
module tb_fifo_serial_tx;

  localparam int WL = 8;
  localparam int BC = 4;
`ifdef TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = 2 + BC * (WL + 2 + PB);

  logic          clk = 1'b0;
  logic          reset, synch_rst, enable;
  logic          fifo_empty, fifo_pop, tx_out, busy, frame_done;
  logic [WL-1:0] fifo_data;

  logic [WL-1:0] mem [16];
  logic [3:0]    rd_ptr = 4'd0;
  logic [3:0]    wr_ptr = 4'd0;

  int checks    = 0;
  int failures  = 0;
  int pop_total = 0;
  int bad_pop   = 0;

  fifo_serial_tx #(.WORDLENGHT(WL), .BIT_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .synch_rst  (synch_rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // Registered-read FIFO: fifo_data shows mem[rd_ptr] one edge late.
  always @(posedge clk) begin
    if (fifo_pop) begin
      pop_total++;
      if (fifo_empty) bad_pop++;
      rd_ptr    <= rd_ptr + 4'd1;
      fifo_data <= mem[rd_ptr + 4'd1];
    end else begin
      fifo_data <= mem[rd_ptr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WL-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  function automatic logic exp_tx(input logic [WL-1:0] d, input int i);
    int b;
    if (i < 2) return 1'b1;
    b = (i - 2) / BC;
    if (b == 0) return 1'b0;
    if (b <= WL) return d[b-1];
`ifdef TX_PARITY_EN
    if (b == WL + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Waits for a frame to begin, then checks every cycle of it plus the IDLE cycle after.
  task automatic expect_frame(input string name, input logic [WL-1:0] data,
                              input int drop_at, output int wait_cycles);
    int n_bad = 0, first_bad = -1, pops = 0, pop_at = -1;
    int dones = 0, done_at = -1, busy_drop = 0;
    wait_cycles = 0;
    while (busy !== 1'b1 && wait_cycles < 100) begin
      tick();
      wait_cycles++;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_start: busy=%b after %0d cycles, required 1", name, busy, wait_cycles);
      return;
    end
    for (int i = 0; i < FL; i++) begin
      if (tx_out !== exp_tx(data, i)) begin
        n_bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (fifo_pop === 1'b1) begin pops++; pop_at = i; end
      if (frame_done === 1'b1) begin dones++; done_at = i; end
      if (busy !== 1'b1) busy_drop++;
      if (i == drop_at) enable = 1'b0;
      tick();
    end
    checks++;
    if (n_bad != 0) begin
      failures++;
      $display("FAIL %s_tx: %0d wrong tx cycles, first at cycle %0d, required 0", name, n_bad, first_bad);
    end
    checks++;
    if (pops != 1 || pop_at != 1) begin
      failures++;
      $display("FAIL %s_pop: %0d pops, last at cycle %0d, required 1 at cycle 1", name, pops, pop_at);
    end
    checks++;
    if (dones != 1 || done_at != FL - 1) begin
      failures++;
      $display("FAIL %s_done: %0d pulses, last at cycle %0d, required 1 at cycle %0d", name, dones, done_at, FL - 1);
    end
    checks++;
    if (busy_drop != 0) begin
      failures++;
      $display("FAIL %s_busy: busy low on %0d frame cycles, required 0", name, busy_drop);
    end
    checks++;
    if (busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL %s_idle: busy=%b tx_out=%b after frame, required busy=0 tx_out=1", name, busy, tx_out);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    int p0;
    reset = 1'b1; synch_rst = 1'b0; enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tx=%b busy=%b pop=%b done=%b, required 1 0 0 0", tx_out, busy, fifo_pop, frame_done);
    end
    reset = 1'b0; enable = 1'b1;
    p0 = pop_total;
    for (int i = 0; i < 20; i++) begin
      if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || pop_total != p0) begin
      failures++;
      $display("FAIL reset_empty_idle: %0d bad cycles, %0d pops, required 0 and 0", bad, pop_total - p0);
    end
  endtask

  task automatic test_single();
    int w;
    push(8'hA5);
    enable = 1'b1;
    expect_frame("single_a5", 8'hA5, -1, w);
  endtask

  task automatic test_back_to_back();
    int w;
    push(8'h3C);
    push(8'hFF);
    enable = 1'b1;
    expect_frame("b2b_3c", 8'h3C, -1, w);
    expect_frame("b2b_ff", 8'hFF, -1, w);
    // One IDLE cycle before SETTLE, LOAD: three idle-high cycles before the start bit.
    checks++;
    if (w != 1) begin
      failures++;
      $display("FAIL b2b_gap: second frame began %0d cycles after stop, required 1", w);
    end
  endtask

  task automatic test_enable_drop();
    int w, p0, bad = 0;
    push(8'h12);
    push(8'h34);
    enable = 1'b1;
    expect_frame("en_drop_12", 8'h12, 10, w);
    p0 = pop_total;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || pop_total != p0) begin
      failures++;
      $display("FAIL en_drop_hold: busy on %0d cycles, %0d pops, required 0 and 0", bad, pop_total - p0);
    end
    enable = 1'b1;
    expect_frame("en_drop_34", 8'h34, -1, w);
  endtask

  task automatic test_synch_rst();
    int w, p0, bad = 0;
    push(8'h00);
    enable = 1'b1;
    w = 0;
    while (busy !== 1'b1 && w < 100) begin tick(); w++; end
    // Cycle 19 is inside data bit 3 of an all-zero word, so the line is low.
    repeat (19) tick();
    checks++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL synch_pre: tx=%b busy=%b, required 0 1", tx_out, busy);
    end
    synch_rst = 1'b1;
    tick();
    synch_rst = 1'b0;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL synch_abort: tx=%b busy=%b, required 1 0", tx_out, busy);
    end
    p0 = pop_total;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || tx_out !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || pop_total != p0) begin
      failures++;
      $display("FAIL synch_hold: %0d bad cycles, %0d pops, required 0 and 0", bad, pop_total - p0);
    end
    push(8'h81);
    expect_frame("synch_resume", 8'h81, -1, w);
  endtask

  task automatic test_async_reset();
    int w = 0;
    push(8'h00);
    enable = 1'b1;
    while (busy !== 1'b1 && w < 100) begin tick(); w++; end
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) begin
      failures++;
      $display("FAIL async_abort: tx=%b busy=%b pop=%b, required 1 0 0", tx_out, busy, fifo_pop);
    end
    tick();
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL async_hold: busy=%b with empty FIFO, required 0", busy);
    end
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity();
    int w;
    logic par_bit;
    push(8'h07);
    enable = 1'b1;
    w = 0;
    while (busy !== 1'b1 && w < 100) begin tick(); w++; end
    // Parity bit occupies cycles 38..41; 0x07 has three ones, so it is 1.
    repeat (39) tick();
    par_bit = tx_out;
    checks++;
    if (par_bit !== 1'b1) begin
      failures++;
      $display("FAIL parity_07_bit: tx=%b, required 1", par_bit);
    end
    repeat (FL - 39) tick();
    push(8'h07);
    expect_frame("parity_07", 8'h07, -1, w);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_drop();
    test_synch_rst();
    test_async_reset();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (bad_pop != 0) begin
      failures++;
      $display("FAIL pop_while_empty: %0d pops with fifo_empty=1, required 0", bad_pop);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
